// File: rtl/gate_pkg.sv
// Shared constants and types for the gate library primitives.
// The count type covers the 0..2 occupancy of the 2-entry skid buffer.
package gate_pkg;

  localparam int WIDTH_MAX = 64;
  localparam int SKID_ENTRIES = 2;

  typedef logic [1:0] count_t;

  localparam count_t CNT_EMPTY = 2'd0;
  localparam count_t CNT_ONE   = 2'd1;
  localparam count_t CNT_FULL  = 2'd2;

endpackage

// File: rtl/h_not_skid.sv
// Generic 2-entry valid/ready skid buffer holding WIDTH bits.
// in_ready and out_valid are registered, so there is no path from out_ready to in_ready.
module h_not_skid
  import gate_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  count_t           count_r;
  count_t           count_s;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] head_s;
  logic [WIDTH-1:0] skid_r;
  logic [WIDTH-1:0] skid_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             push_s;
  logic             pop_s;

  assign push_s = in_valid && in_ready_r;
  assign pop_s  = out_valid_r && out_ready;

  // Next-state for occupancy and the two storage entries.
  always_comb begin
    count_s = count_r;
    head_s  = head_r;
    skid_s  = skid_r;
    case ({push_s, pop_s})
      2'b10: begin
        if (count_r == CNT_EMPTY) begin
          head_s = in_data;
        end else begin
          skid_s = in_data;
        end
        count_s = count_r + CNT_ONE;
      end
      2'b01: begin
        if (count_r == CNT_FULL) begin
          head_s = skid_r;
        end else begin
          head_s = head_r;
        end
        count_s = count_r - CNT_ONE;
      end
      2'b11: begin
        // Occupancy unchanged; the queue shifts by one entry.
        if (count_r == CNT_FULL) begin
          head_s = skid_r;
          skid_s = in_data;
        end else begin
          head_s = in_data;
        end
      end
      default: begin
        count_s = count_r;
      end
    endcase
  end

  // Storage and handshake registers; reset discards any buffered words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r     <= CNT_EMPTY;
      head_r      <= {WIDTH{1'b0}};
      skid_r      <= {WIDTH{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      count_r     <= count_s;
      head_r      <= head_s;
      skid_r      <= skid_s;
      in_ready_r  <= (count_s != CNT_FULL);
      out_valid_r <= (count_s != CNT_EMPTY);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = head_r;

endmodule

// File: rtl/h_not.sv
// Bitwise inverter: combinational out = ~in, plus a registered,
// flow-controlled copy of ~in delivered through a 2-entry skid buffer.
module h_not
  import gate_pkg::*;
#(
  parameter int WIDTH      = 1,
  parameter int SKID_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] inv_s;

  if (SKID_DEPTH != SKID_ENTRIES || WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_param_check
    $error("h_not: illegal parameters (WIDTH must be 1..64, SKID_DEPTH must be 2)");
  end

  // Plain NOT: no clock or reset involvement, X/Z pass through per bit.
  assign inv_s = ~in;
  assign out   = inv_s;

  h_not_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_data  (inv_s),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_q),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

endmodule

// File: tb/tb_h_not.sv
// Self-checking bench for h_not: directed checks on WIDTH=1 and WIDTH=8
// instances, then a randomized WIDTH=16 run against a queue-based model.
module tb_h_not;

  logic clk;
  logic reset;

  logic       in1;
  logic       out1;
  logic       ir1;
  logic       oq1;
  logic       ov1;

  logic [7:0] in8;
  logic [7:0] out8;
  logic       iv8;
  logic       ir8;
  logic [7:0] oq8;
  logic       ov8;
  logic       ordy8;

  logic [15:0] in16;
  logic [15:0] out16;
  logic        iv16;
  logic        ir16;
  logic [15:0] oq16;
  logic        ov16;
  logic        ordy16;

  int checks;
  int failures;

  h_not #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .in(in1), .out(out1),
    .in_valid(1'b0), .in_ready(ir1), .out_q(oq1), .out_valid(ov1), .out_ready(1'b0)
  );

  h_not #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in(in8), .out(out8),
    .in_valid(iv8), .in_ready(ir8), .out_q(oq8), .out_valid(ov8), .out_ready(ordy8)
  );

  h_not #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .in(in16), .out(out16),
    .in_valid(iv16), .in_ready(ir16), .out_q(oq16), .out_valid(ov16), .out_ready(ordy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] model_q[$];
  logic [15:0] model_last;
  logic        push_m;
  logic        pop_m;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    in1      = 1'b0;
    in8      = 8'h00;
    iv8      = 1'b0;
    ordy8    = 1'b0;
    in16     = 16'h0000;
    iv16     = 1'b0;
    ordy16   = 1'b0;

    // Combinational path while reset is asserted.
    #1;
    check_eq("comb_rst_in0", {63'd0, out1}, 64'd1);
    in1 = 1'b1;
    #1;
    check_eq("comb_rst_in1", {63'd0, out1}, 64'd0);
    in8 = 8'h3C;
    #1;
    check_eq("comb_rst_w8", {56'd0, out8}, 64'hC3);

    // Reset state of the registered path.
    check_eq("rst_in_ready", {63'd0, ir8}, 64'd1);
    check_eq("rst_out_valid", {63'd0, ov8}, 64'd0);
    check_eq("rst_out_q", {56'd0, oq8}, 64'd0);

    @(negedge clk);
    reset = 1'b0;
    in1 = 1'b0;
    #100;
    check_eq("comb_in0", {63'd0, out1}, 64'd1);
    in1 = 1'b1;
    #100;
    check_eq("comb_in1", {63'd0, out1}, 64'd0);

    // Single transfer with consumer always ready.
    tick();
    ordy8 = 1'b1;
    in8   = 8'hA5;
    iv8   = 1'b1;
    tick();
    iv8 = 1'b0;
    check_eq("t2_valid", {63'd0, ov8}, 64'd1);
    check_eq("t2_data", {56'd0, oq8}, 64'h5A);
    tick();
    check_eq("t2_drained", {63'd0, ov8}, 64'd0);
    check_eq("t2_hold", {56'd0, oq8}, 64'h5A);

    // Back-to-back into a stalled consumer.
    ordy8 = 1'b0;
    in8 = 8'h00; iv8 = 1'b1;
    tick();
    check_eq("t3_ready_1", {63'd0, ir8}, 64'd1);
    in8 = 8'h0F;
    tick();
    in8 = 8'hF0;
    check_eq("t3_full_ready", {63'd0, ir8}, 64'd0);
    check_eq("t3_head_a", {56'd0, oq8}, 64'hFF);
    tick();
    check_eq("t3_still_full", {63'd0, ir8}, 64'd0);
    check_eq("t3_head_b", {56'd0, oq8}, 64'hFF);
    ordy8 = 1'b1;
    tick();
    check_eq("t3_head_c", {56'd0, oq8}, 64'hF0);
    check_eq("t3_ready_again", {63'd0, ir8}, 64'd1);
    tick();
    iv8 = 1'b0;
    check_eq("t3_head_d", {56'd0, oq8}, 64'h0F);
    check_eq("t3_valid_d", {63'd0, ov8}, 64'd1);
    tick();
    check_eq("t3_empty", {63'd0, ov8}, 64'd0);

    // Simultaneous in/out with one word buffered.
    ordy8 = 1'b0;
    in8 = 8'h11; iv8 = 1'b1;
    tick();
    in8 = 8'h3C; ordy8 = 1'b1;
    tick();
    iv8 = 1'b0; ordy8 = 1'b0;
    check_eq("t4_data", {56'd0, oq8}, 64'hC3);
    check_eq("t4_valid", {63'd0, ov8}, 64'd1);
    check_eq("t4_ready", {63'd0, ir8}, 64'd1);
    tick();
    check_eq("t4_count1", {56'd0, oq8}, 64'hC3);
    ordy8 = 1'b1;
    tick();
    check_eq("t4_empty", {63'd0, ov8}, 64'd0);

    // Asynchronous reset while full, then first word after reset.
    ordy8 = 1'b0;
    in8 = 8'h12; iv8 = 1'b1;
    tick();
    in8 = 8'h34;
    tick();
    iv8 = 1'b0;
    check_eq("t5_full", {63'd0, ir8}, 64'd0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("t5_rst_ready", {63'd0, ir8}, 64'd1);
    check_eq("t5_rst_valid", {63'd0, ov8}, 64'd0);
    check_eq("t5_rst_q", {56'd0, oq8}, 64'd0);
    #2;
    reset = 1'b0;
    in8 = 8'h96; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    check_eq("t5_post_data", {56'd0, oq8}, 64'h69);
    check_eq("t5_post_valid", {63'd0, ov8}, 64'd1);
    ordy8 = 1'b1;
    tick();
    check_eq("t5_post_empty", {63'd0, ov8}, 64'd0);

    // Randomized flow against a FIFO model of capacity 2.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_q.delete();
    model_last = 16'h0000;
    tick();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in16   = 16'($urandom);
      iv16   = 1'($urandom_range(0, 1));
      ordy16 = ($urandom_range(0, 3) != 0);
      push_m = iv16 && (model_q.size() < 2);
      pop_m  = ordy16 && (model_q.size() != 0);
      tick();
      if (pop_m) begin
        model_last = model_q.pop_front();
      end
      if (push_m) begin
        model_q.push_back(~in16);
      end
      if (model_q.size() != 0) begin
        model_last = model_q[0];
      end
      check_eq("rnd_in_ready", {63'd0, ir16}, {63'd0, (model_q.size() < 2)});
      check_eq("rnd_out_valid", {63'd0, ov16}, {63'd0, (model_q.size() != 0)});
      check_eq("rnd_out_q", {48'd0, oq16}, {48'd0, model_last});
      check_eq("rnd_comb", {48'd0, out16}, {48'd0, ~in16});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
